reg_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback requesters:
//  req0 (ALU) and req1 (memory/load).

---
 rtl/reg_wb_arbiter_pkg.sv | 10 +
 rtl/reg_wb_arbiter_scoreboard.sv | 71 +++++++
 rtl/reg_wb_arbiter.sv | 108 ++++++++++
 tb/tb_reg_wb_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// reg_wb_arbiter_pkg
//   Shared widths for the writeback path and register file, plus the
//   requester index constants used by the round-robin pointer.
package reg_wb_arbiter_pkg;
    localparam int   WB_DATA_WIDTH = 32;  // writeback / register data width
    localparam int   WB_ADDR_WIDTH = 5;   // register index width
    localparam int   WB_CNT_WIDTH  = 2;   // pending-write counter width
    localparam logic REQ_ALU       = 1'b0;
    localparam logic REQ_MEM       = 1'b1;
endpackage

// File: rtl/reg_wb_arbiter_scoreboard.sv
// wb_scoreboard
//   Per-register pending-write counters. Decode issues a destination (inc),
//   the register-file commit retires it (dec). Reports RAW hazards for two
//   source registers and a sticky error when a commit finds nothing pending.
// Ports
//   i_clk, i_rst               clock, async active-high reset
//   i_iss_valid/i_iss_addr     issue of an instruction writing i_iss_addr
//   o_iss_ready                issue accepted (counter not saturated)
//   i_cmt_en/i_cmt_addr        register-file write this cycle
//   i_chk_addr1/2, o_hazard1/2 source registers and their hazard flags
//   o_sb_err                   sticky commit-without-pending flag
module wb_scoreboard
    import reg_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int CNT_WIDTH  = WB_CNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_iss_valid,
    input  logic [ADDR_WIDTH-1:0] i_iss_addr,
    output logic                  o_iss_ready,
    input  logic                  i_cmt_en,
    input  logic [ADDR_WIDTH-1:0] i_cmt_addr,
    input  logic [ADDR_WIDTH-1:0] i_chk_addr1,
    input  logic [ADDR_WIDTH-1:0] i_chk_addr2,
    output logic                  o_hazard1,
    output logic                  o_hazard2,
    output logic                  o_sb_err
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NREG-1:0][CNT_WIDTH-1:0] r_cnt;
    logic                           r_sb_err;
    logic                           w_inc;
    logic                           w_underflow;
    logic [NREG-1:0]                w_inc_vec;
    logic [NREG-1:0]                w_dec_vec;

    assign o_iss_ready = (i_iss_addr == '0) || (r_cnt[i_iss_addr] != CNT_MAX);
    assign w_inc       = i_iss_valid && o_iss_ready && (i_iss_addr != '0);

    // One-hot inc/dec masks; bit 0 is masked so r0 never holds a count.
    assign w_inc_vec = (w_inc    ? (NREG'(1) << i_iss_addr) : '0) & ~NREG'(1);
    assign w_dec_vec = (i_cmt_en ? (NREG'(1) << i_cmt_addr) : '0) & ~NREG'(1);

    assign w_underflow = i_cmt_en && (i_cmt_addr != '0) && (r_cnt[i_cmt_addr] == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                case ({w_inc_vec[r], w_dec_vec[r]})
                    2'b10:   r_cnt[r] <= r_cnt[r] + 1'b1;
                    // underflow saturates at zero; the error flag records it
                    2'b01:   if (r_cnt[r] != '0) r_cnt[r] <= r_cnt[r] - 1'b1;
                    default: ;  // idle, or issue and commit cancel out
                endcase
            end
            if (w_underflow) r_sb_err <= 1'b1;
        end
    end

    // No bypass: the register committing this cycle still reports a hazard.
    assign o_hazard1 = (i_chk_addr1 != '0) && (r_cnt[i_chk_addr1] != '0);
    assign o_hazard2 = (i_chk_addr2 != '0) && (r_cnt[i_chk_addr2] != '0);
    assign o_sb_err  = r_sb_err;
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
//   Round-robin arbiter sharing the register-file write port between the ALU
//   (req0) and memory/load (req1) writeback requesters, with a one-cycle
//   registered output stage and a pending-write scoreboard for RAW detection.
// Ports
//   i_clk, i_rst                      clock, async active-high reset
//   i_req{0,1}_valid/addr/data        writeback requests
//   o_req{0,1}_ready                  grant (at most one per cycle)
//   o_rf_wen/o_rf_waddr/o_rf_wdata    register-file write port
//   i_iss_valid/i_iss_addr/o_iss_ready decode issue into the scoreboard
//   i_chk_addr{1,2}, o_hazard{1,2}    RAW hazard lookups
//   o_sb_err                          sticky scoreboard underflow
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int CNT_WIDTH  = WB_CNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic [ADDR_WIDTH-1:0] i_req0_addr,
    input  logic [DATA_WIDTH-1:0] i_req0_data,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic [ADDR_WIDTH-1:0] i_req1_addr,
    input  logic [DATA_WIDTH-1:0] i_req1_data,
    output logic                  o_rf_wen,
    output logic [ADDR_WIDTH-1:0] o_rf_waddr,
    output logic [DATA_WIDTH-1:0] o_rf_wdata,
    input  logic                  i_iss_valid,
    output logic                  o_iss_ready,
    input  logic [ADDR_WIDTH-1:0] i_iss_addr,
    input  logic [ADDR_WIDTH-1:0] i_chk_addr1,
    input  logic [ADDR_WIDTH-1:0] i_chk_addr2,
    output logic                  o_hazard1,
    output logic                  o_hazard2,
    output logic                  o_sb_err
);
    logic                  r_rr;
    logic                  r_rf_wen;
    logic [ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0] r_rf_wdata;

    logic                  w_both;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // Pointer only matters on contention; a lone requester always wins.
    assign w_both = i_req0_valid && i_req1_valid;
    assign w_gnt0 = i_req0_valid && (!i_req1_valid || (r_rr == REQ_ALU));
    assign w_gnt1 = i_req1_valid && (!i_req0_valid || (r_rr == REQ_MEM));

    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;

    assign w_sel_addr = w_gnt1 ? i_req1_addr : i_req0_addr;
    assign w_sel_data = w_gnt1 ? i_req1_data : i_req0_data;

    // After any grant the pointer favours the requester that did not win.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)          r_rr <= REQ_ALU;
        else if (w_both)    r_rr <= ~r_rr;
        else if (w_gnt0)    r_rr <= REQ_MEM;
        else if (w_gnt1)    r_rr <= REQ_ALU;
    end

    // Writes to r0 are consumed but never reach the register file.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else if ((w_gnt0 || w_gnt1) && (w_sel_addr != '0)) begin
            r_rf_wen   <= 1'b1;
            r_rf_waddr <= w_sel_addr;
            r_rf_wdata <= w_sel_data;
        end else begin
            r_rf_wen   <= 1'b0;
        end
    end

    assign o_rf_wen   = r_rf_wen;
    assign o_rf_waddr = r_rf_waddr;
    assign o_rf_wdata = r_rf_wdata;

    wb_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_sb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_iss_valid (i_iss_valid),
        .i_iss_addr  (i_iss_addr),
        .o_iss_ready (o_iss_ready),
        .i_cmt_en    (r_rf_wen),
        .i_cmt_addr  (r_rf_waddr),
        .i_chk_addr1 (i_chk_addr1),
        .i_chk_addr2 (i_chk_addr2),
        .o_hazard1   (o_hazard1),
        .o_hazard2   (o_hazard2),
        .o_sb_err    (o_sb_err)
    );
endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 32;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          iss_valid, iss_ready;
    logic [AW-1:0] iss_addr, chk_addr1, chk_addr2;
    logic          hazard1, hazard2, sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
        .i_req0_addr(req0_addr), .i_req0_data(req0_data),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
        .i_req1_addr(req1_addr), .i_req1_data(req1_data),
        .o_rf_wen(rf_wen), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
        .i_iss_valid(iss_valid), .o_iss_ready(iss_ready), .i_iss_addr(iss_addr),
        .i_chk_addr1(chk_addr1), .i_chk_addr2(chk_addr2),
        .o_hazard1(hazard1), .o_hazard2(hazard2), .o_sb_err(sb_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        iss_valid  = 1'b0; iss_addr  = '0;
        chk_addr1  = '0;   chk_addr2 = '0;
    endtask

    // Each cycle starts at posedge+1; checks happen mid-cycle at the negedge.
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic v0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic v1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic iv; logic [AW-1:0] ia; logic [AW-1:0] c1; logic [AW-1:0] c2;
        logic e_r0, e_r1, e_wen; logic [AW-1:0] e_wa; logic [DW-1:0] e_wd;
        logic e_irdy, e_h1, e_h2;
    } vec_t;

    function automatic vec_t mk(
        input logic v0, input int a0, input int d0, input logic v1, input int a1, input int d1,
        input logic iv, input int ia, input int c1, input int c2,
        input logic r0, input logic r1, input logic wen, input int wa, input int wd,
        input logic irdy, input logic h1, input logic h2);
        vec_t v;
        v.v0 = v0; v.a0 = AW'(a0); v.d0 = DW'(d0);
        v.v1 = v1; v.a1 = AW'(a1); v.d1 = DW'(d1);
        v.iv = iv; v.ia = AW'(ia); v.c1 = AW'(c1); v.c2 = AW'(c2);
        v.e_r0 = r0; v.e_r1 = r1; v.e_wen = wen; v.e_wa = AW'(wa); v.e_wd = DW'(wd);
        v.e_irdy = irdy; v.e_h1 = h1; v.e_h2 = h2;
        return v;
    endfunction

    vec_t tbl[9];

    // reference model state
    int            m_cnt[NREG];
    bit            m_rr;
    logic          m_wen;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    bit            m_err;

    initial begin
        logic g0, g1, inc, irdy_e;
        //            v0 a0 d0       v1 a1 d1       iv ia c1 c2  r0 r1 wen wa wd       irdy h1 h2
        tbl[0] = mk(0, 0, 0,        0, 0, 0,        1, 3, 3, 5,  0, 0, 0, 0, 0,        1, 0, 0);
        tbl[1] = mk(1, 3, 'h1234,   0, 0, 0,        1, 5, 3, 5,  1, 0, 0, 0, 0,        1, 1, 0);
        tbl[2] = mk(1, 5, 'hAAAA,   1, 5, 'hBBBB,   1, 5, 3, 5,  0, 1, 1, 3, 'h1234,   1, 1, 1);
        tbl[3] = mk(1, 5, 'hAAAA,   0, 0, 0,        1, 5, 5, 5,  1, 0, 1, 5, 'hBBBB,   1, 1, 1);
        tbl[4] = mk(0, 0, 0,        0, 0, 0,        1, 5, 3, 5,  0, 0, 1, 5, 'hAAAA,   1, 0, 1);
        tbl[5] = mk(0, 0, 0,        1, 0, 'hCCCC,   1, 5, 5, 5,  0, 1, 0, 5, 'hAAAA,   1, 1, 1);
        tbl[6] = mk(0, 0, 0,        0, 0, 0,        1, 5, 5, 5,  0, 0, 0, 5, 'hAAAA,   0, 1, 1);
        tbl[7] = mk(0, 0, 0,        0, 0, 0,        1, 6, 6, 5,  0, 0, 0, 5, 'hAAAA,   1, 0, 1);
        tbl[8] = mk(0, 0, 0,        0, 0, 0,        0, 5, 6, 5,  0, 0, 0, 5, 'hAAAA,   0, 1, 1);

        // ---- reset state ----
        rst = 1'b1; idle(); chk_addr1 = 5;
        next_cycle(); #4;
        chk("rst_wen", 64'(rf_wen), 0);
        chk("rst_waddr", 64'(rf_waddr), 0);
        chk("rst_wdata", 64'(rf_wdata), 0);
        chk("rst_sberr", 64'(sb_err), 0);
        chk("rst_haz1", 64'(hazard1), 0);
        next_cycle(); rst = 1'b0;

        // ---- table-driven vectors ----
        for (int i = 0; i < 9; i++) begin
            req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = tbl[i].d1;
            iss_valid = tbl[i].iv; iss_addr = tbl[i].ia;
            chk_addr1 = tbl[i].c1; chk_addr2 = tbl[i].c2;
            #4;
            chk($sformatf("tbl%0d_r0", i), 64'(req0_ready), 64'(tbl[i].e_r0));
            chk($sformatf("tbl%0d_r1", i), 64'(req1_ready), 64'(tbl[i].e_r1));
            chk($sformatf("tbl%0d_wen", i), 64'(rf_wen), 64'(tbl[i].e_wen));
            chk($sformatf("tbl%0d_waddr", i), 64'(rf_waddr), 64'(tbl[i].e_wa));
            chk($sformatf("tbl%0d_wdata", i), 64'(rf_wdata), 64'(tbl[i].e_wd));
            chk($sformatf("tbl%0d_issrdy", i), 64'(iss_ready), 64'(tbl[i].e_irdy));
            chk($sformatf("tbl%0d_haz1", i), 64'(hazard1), 64'(tbl[i].e_h1));
            chk($sformatf("tbl%0d_haz2", i), 64'(hazard2), 64'(tbl[i].e_h2));
            chk($sformatf("tbl%0d_sberr", i), 64'(sb_err), 0);
            next_cycle();
        end
        idle();

        // ---- r5 holds 3 pending: three commits clear the hazard ----
        chk_addr1 = 5;
        for (int k = 0; k < 5; k++) begin
            req0_valid = (k < 3); req0_addr = 5; req0_data = DW'(k + 1);
            #4;
            chk("r5_haz1", 64'(hazard1), 64'(k < 4));
            if (k >= 1 && k <= 3) chk("r5_wdata", 64'(rf_wdata), 64'(k));
            next_cycle();
        end
        chk("r5_sberr", 64'(sb_err), 0);
        idle();

        // ---- issue and commit r7 in the same cycle ----
        chk_addr1 = 7; iss_valid = 1; iss_addr = 7;
        #4; chk("r7_iss0_rdy", 64'(iss_ready), 1); chk("r7_haz_pre", 64'(hazard1), 0);
        next_cycle();
        iss_valid = 0; req0_valid = 1; req0_addr = 7; req0_data = 'h77;
        #4; chk("r7_gnt", 64'(req0_ready), 1); chk("r7_haz_a", 64'(hazard1), 1);
        next_cycle();
        req0_valid = 0; iss_valid = 1; iss_addr = 7;
        #4; chk("r7_wen", 64'(rf_wen), 1); chk("r7_waddr", 64'(rf_waddr), 7);
        chk("r7_haz_b", 64'(hazard1), 1);
        next_cycle();
        iss_valid = 0;
        #4; chk("r7_haz_c", 64'(hazard1), 1);
        next_cycle();
        #4; chk("r7_haz_d", 64'(hazard1), 1); chk("r7_sberr", 64'(sb_err), 0);
        next_cycle();

        // ---- commit to r9 with nothing pending; then addr 0 request ----
        chk_addr1 = 9; req1_valid = 1; req1_addr = 9; req1_data = 'h99;
        #4; chk("r9_r1", 64'(req1_ready), 1); chk("r9_r0", 64'(req0_ready), 0);
        next_cycle();
        req1_valid = 0;
        #4; chk("r9_wen", 64'(rf_wen), 1); chk("r9_wdata", 64'(rf_wdata), 'h99);
        chk("r9_sberr_pre", 64'(sb_err), 0);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            #4; chk("r9_sberr_sticky", 64'(sb_err), 1);
            next_cycle();
        end
        req1_valid = 1; req1_addr = 0; req1_data = 'hCC;
        #4; chk("a0_ready", 64'(req1_ready), 1);
        next_cycle();
        req1_valid = 0;
        #4; chk("a0_wen", 64'(rf_wen), 0); chk("a0_sberr", 64'(sb_err), 1);
        next_cycle();

        // ---- async reset with a write in flight ----
        iss_valid = 1; iss_addr = 4;
        next_cycle();
        iss_valid = 0; req0_valid = 1; req0_addr = 4; req0_data = 'h44;
        next_cycle();
        req0_valid = 0;
        #2; rst = 1'b1; #1;
        chk("arst_wen", 64'(rf_wen), 0);
        chk("arst_waddr", 64'(rf_waddr), 0);
        chk("arst_wdata", 64'(rf_wdata), 0);
        chk("arst_sberr", 64'(sb_err), 0);
        for (int c = 0; c < NREG; c++) begin
            chk_addr1 = AW'(c); #1;
            chk($sformatf("arst_haz1_r%0d", c), 64'(hazard1), 0);
        end
        idle();
        next_cycle(); rst = 1'b0;

        // ---- contention from reset: grants alternate 0,1,0,1 ----
        for (int k = 0; k < 5; k++) begin
            req0_valid = (k < 4); req0_addr = 1; req0_data = 'h10;
            req1_valid = (k < 4); req1_addr = 2; req1_data = 'h20;
            #4;
            if (k < 4) begin
                chk("rr_r0", 64'(req0_ready), 64'(k % 2 == 0));
                chk("rr_r1", 64'(req1_ready), 64'(k % 2 == 1));
            end
            if (k > 0) begin
                chk("rr_wen", 64'(rf_wen), 1);
                chk("rr_waddr", 64'(rf_waddr), ((k - 1) % 2 == 0) ? 1 : 2);
                chk("rr_wdata", 64'(rf_wdata), ((k - 1) % 2 == 0) ? 'h10 : 'h20);
            end
            next_cycle();
        end

        // ---- randomized run against the reference model ----
        rst = 1'b1; idle(); next_cycle(); rst = 1'b0;
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
        m_rr = 0; m_wen = 0; m_wa = '0; m_wd = '0; m_err = 0;
        for (int n = 0; n < 400; n++) begin
            #4;
            g0 = req0_valid && (!req1_valid || !m_rr);
            g1 = req1_valid && (!req0_valid || m_rr);
            irdy_e = (iss_addr == 0) || (m_cnt[iss_addr] != CMAX);
            chk("rnd_r0", 64'(req0_ready), 64'(g0));
            chk("rnd_r1", 64'(req1_ready), 64'(g1));
            chk("rnd_wen", 64'(rf_wen), 64'(m_wen));
            chk("rnd_waddr", 64'(rf_waddr), 64'(m_wa));
            chk("rnd_wdata", 64'(rf_wdata), 64'(m_wd));
            chk("rnd_issrdy", 64'(iss_ready), 64'(irdy_e));
            chk("rnd_haz1", 64'(hazard1), 64'(chk_addr1 != 0 && m_cnt[chk_addr1] != 0));
            chk("rnd_haz2", 64'(hazard2), 64'(chk_addr2 != 0 && m_cnt[chk_addr2] != 0));
            chk("rnd_sberr", 64'(sb_err), 64'(m_err));
            // model step at the coming edge
            inc = iss_valid && irdy_e && (iss_addr != 0);
            if (m_wen && m_cnt[m_wa] == 0) m_err = 1;
            if (inc && !(m_wen && m_wa == iss_addr)) m_cnt[iss_addr]++;
            if (m_wen && !(inc && m_wa == iss_addr) && m_cnt[m_wa] > 0) m_cnt[m_wa]--;
            if (req0_valid && req1_valid) m_rr = !m_rr;
            else if (req0_valid)          m_rr = 1;
            else if (req1_valid)          m_rr = 0;
            if ((g0 && req0_addr != 0) || (g1 && req1_addr != 0)) begin
                m_wen = 1;
                m_wa  = g1 ? req1_addr : req0_addr;
                m_wd  = g1 ? req1_data : req0_data;
            end else begin
                m_wen = 0;
            end
            next_cycle();
            // a requester not granted keeps its request stable
            if (!req0_valid || g0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_addr  = AW'($urandom_range(0, 7));
                req0_data  = $urandom;
            end
            if (!req1_valid || g1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_addr  = AW'($urandom_range(0, 7));
                req1_data  = $urandom;
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_addr  = AW'($urandom_range(0, 7));
            chk_addr1 = AW'($urandom_range(0, 7));
            chk_addr2 = AW'($urandom_range(0, 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
